multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Parametrised control unit for the multicycle MIPS-style datapath. It is the successor to the fixed five-state sequencer, and adds three things: a valid/ready memory handshake with arbitrary wait states, `ADDI` support, and an optional undefined-opcode trap. It sits beside `Datapath`, takes the opcode from the IR, and drives every datapath control line. `DATA_W` lets the same block serve both the 32-bit MIPS and the 64-bit LEG datapaths.

## Interface
- `DATA_W`, default 32: datapath width (32 or 64); sets the width of `exc_vector`.
- `EXC_VECTOR`, default `'h180`: trap target address, zero-extended to `DATA_W`.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 6: IR[31:26]; stable from the cycle after `IRWrite` until the next fetch.
- `mem_ready` in 1: memory completes the current access in this cycle.
- `mem_req` out 1: equals `MemRead | MemWrite`.
- `ALUOp`, `ALUSrcB`, `PCSource` out 2 each: same encodings as `Datapath`; `PCSource` 2'b11 selects `exc_vector`.
- `RegDst`, `MemtoReg`, `MemRead`, `MemWrite`, `IorD`, `RegWrite`, `IRWrite`, `PCWrite`, `PCWriteCond`, `ALUSrcA` out 1 each.
- `EPCWrite` out 1: latch the faulting PC (trap build only; tied 0 otherwise).
- `exc_vector` out `DATA_W`: constant `EXC_VECTOR`.
- `state_o` out 3: current state, for debug and coverage.

## Operation
- States: FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, EXC=6. Reset enters FETCH.
- FETCH
  - Outputs: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=00.
  - `IRWrite` = `PCWrite` = `mem_ready`.
  - Holds in FETCH until `mem_ready`, then goes to DECODE.
- DECODE
  - Outputs: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00 (branch target into ALUOut).
  - Goes to EXEC for a legal opcode: R=0, LW=0x23, SW=0x2B, BEQ=0x04, J=0x02, ADDI=0x08.
  - Any other opcode is handled as described under Configuration.
- EXEC
  - LW, SW, ADDI: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. LW and SW go to MEM; ADDI goes to WB.
  - R-type: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10, then WB.
  - BEQ: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01, then FETCH.
  - J: `PCWrite`=1, `PCSource`=10, then FETCH.
- MEM
  - Outputs: `IorD`=1; LW drives `MemRead`=1, SW drives `MemWrite`=1.
  - Holds until `mem_ready`. LW then goes to WB; SW goes to FETCH.
  - The request stays asserted, unchanged, for every wait cycle.
- WB
  - Outputs: `RegWrite`=1 for one cycle, then FETCH.
  - R-type: `RegDst`=1, `MemtoReg`=0.
  - LW: `RegDst`=0, `MemtoReg`=1.
  - ADDI: `RegDst`=0, `MemtoReg`=0.
- EXC: `PCWrite`=1, `PCSource`=11, `EPCWrite`=1, then FETCH.
- Signals not listed for a state are 0.
- The state register uses `reset` asynchronously. All outputs are combinational from state, `opcode` and `mem_ready`.

## Timing
- While `reset`=1: every enable (`IRWrite`, `PCWrite`, `PCWriteCond`, `RegWrite`, `MemRead`, `MemWrite`, `mem_req`, `EPCWrite`) is 0, all selects are 0, and `state_o`=1.
- First `mem_req` appears in the first cycle after `reset` deasserts.
- Cycles per instruction with zero wait states: J=3, BEQ=3, R=4, ADDI=4, SW=4, LW=5. Each memory access adds one cycle per cycle `mem_ready` is low.
- `mem_ready` outside FETCH and MEM is ignored.
- `mem_ready` is sampled only on the edge that ends the access. `IRWrite`, `PCWrite` and the MEM exit all qualify on the same cycle.
- Reset asserted mid-access drops `mem_req` immediately, with no completion. The memory side must tolerate an abandoned request.
- BEQ: the PC updates only if `Zero` is high in EXEC. The controller does not sample `Zero`.

## Configuration
- `MULTICYCLE_CTRL_EXC_EN` defined: an undefined opcode in DECODE goes to EXC. That is one extra cycle: the PC loads `EXC_VECTOR` and EPC captures the PC.
- Undefined: an undefined opcode in DECODE goes straight to FETCH, so it behaves as a 2-cycle NOP. State EXC is unreachable, and `EPCWrite` is tied 0.

## Structure
- Shared package `mc_pkg` holds:
  - opcode constants;
  - the state enum;
  - `ALUOp`, `ALUSrcB` and `PCSource` encodings, including `PCS_EXC`=2'b11.
- Sub-module `mc_opdecode`: opcode to one-hot class {R, LW, SW, BEQ, J, ADDI, ILLEGAL}. The FSM and the output logic both consume these classes.

## Test plan
- Reset, then R-type (op 0), `mem_ready` held 1: states 1,2,3,5,1. `RegWrite` is high for exactly one cycle with `RegDst`=1. Total 4 cycles.
- LW (0x23), `mem_ready` low for 2 cycles in FETCH and 3 cycles in MEM:
  - 10 cycles total;
  - `MemRead` is held across all wait cycles;
  - `IRWrite` pulses once;
  - WB drives `MemtoReg`=1.
- SW (0x2B), then BEQ (0x04), then J (0x02), zero wait: SW has `MemWrite` for 1 cycle and takes 4 cycles. BEQ has `PCWriteCond`=1 with `PCSource`=01; J has `PCWrite`=1 with `PCSource`=10; each takes 3 cycles.
- ADDI (0x08): EXEC drives `ALUSrcB`=10; WB drives `RegDst`=0 and `MemtoReg`=0; 4 cycles.
- Opcode 0x3F:
  - with `MULTICYCLE_CTRL_EXC_EN`: `state_o` shows 6 for one cycle with `PCSource`=11 and `EPCWrite`=1, then returns to 1;
  - without it: DECODE goes to FETCH and `EPCWrite` stays 0.
- `reset` pulsed in MEM during an LW wait: `mem_req` drops to 0 in the same cycle, `state_o`=1, and there is no `RegWrite`.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: opcodes, state encoding,
// datapath select encodings and the decoded opcode class.
`default_nettype none

package mc_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_EXC    = 3'd6
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_EXC    = 2'b11;

  typedef struct packed {
    logic r;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic addi;
    logic illegal;
  } opclass_t;

endpackage

`default_nettype wire

// File: rtl/mc_opdecode.sv
// Opcode to one-hot instruction class; any unlisted opcode is ILLEGAL.
`default_nettype none

module mc_opdecode
  import mc_pkg::*;
(
  input  logic [5:0] i_opcode,
  output opclass_t   o_class
);

  always_comb begin
    o_class = '0;
    case (i_opcode)
      OP_R:    o_class.r       = 1'b1;
      OP_LW:   o_class.lw      = 1'b1;
      OP_SW:   o_class.sw      = 1'b1;
      OP_BEQ:  o_class.beq     = 1'b1;
      OP_J:    o_class.j       = 1'b1;
      OP_ADDI: o_class.addi    = 1'b1;
      default: o_class.illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS/LEG control unit with valid/ready memory handshake.
// Build option MULTICYCLE_CTRL_EXC_EN: undefined opcodes trap to EXC_VECTOR.
`default_nettype none

module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] EXC_VECTOR = 'h180
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [5:0]        opcode,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic [1:0]        ALUOp,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        PCSource,
  output logic              RegDst,
  output logic              MemtoReg,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              IorD,
  output logic              RegWrite,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic              PCWriteCond,
  output logic              ALUSrcA,
  output logic              EPCWrite,
  output logic [DATA_W-1:0] exc_vector,
  output logic [2:0]        state_o
);

  state_t   r_state;
  opclass_t w_cls;

  mc_opdecode u_opdecode (
    .i_opcode (opcode),
    .o_class  (w_cls)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          if (w_cls.illegal) begin
`ifdef MULTICYCLE_CTRL_EXC_EN
            r_state <= S_EXC;
`else
            r_state <= S_FETCH;
`endif
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_cls.lw || w_cls.sw)       r_state <= S_MEM;
          else if (w_cls.r || w_cls.addi) r_state <= S_WB;
          else                            r_state <= S_FETCH;
        end
        S_MEM:    if (mem_ready) r_state <= w_cls.lw ? S_WB : S_FETCH;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Outputs are combinational so that reset blanks every enable in the same cycle.
  always_comb begin
    ALUOp       = ALUOP_ADD;
    ALUSrcB     = SRCB_REG;
    PCSource    = PCS_ALU;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    RegWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    ALUSrcA     = 1'b0;
    EPCWrite    = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: ALUSrcB = SRCB_BRANCH;
        S_EXEC: begin
          if (w_cls.lw || w_cls.sw || w_cls.addi) begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
          end else if (w_cls.r) begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
          end else if (w_cls.beq) begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCS_ALUOUT;
          end else if (w_cls.j) begin
            PCWrite  = 1'b1;
            PCSource = PCS_JUMP;
          end
        end
        S_MEM: begin
          IorD     = 1'b1;
          MemRead  = w_cls.lw;
          MemWrite = w_cls.sw;
        end
        S_WB: begin
          RegWrite = 1'b1;
          RegDst   = w_cls.r;
          MemtoReg = w_cls.lw;
        end
`ifdef MULTICYCLE_CTRL_EXC_EN
        S_EXC: begin
          PCWrite  = 1'b1;
          PCSource = PCS_EXC;
          EPCWrite = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign mem_req    = MemRead | MemWrite;
  assign exc_vector = EXC_VECTOR;
  assign state_o    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: per-cycle control vectors per instruction.
`default_nettype none

module tb_multicycle_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        mem_req;
  logic [1:0]  ALUOp, ALUSrcB, PCSource;
  logic        RegDst, MemtoReg, MemRead, MemWrite, IorD, RegWrite;
  logic        IRWrite, PCWrite, PCWriteCond, ALUSrcA, EPCWrite;
  logic [31:0] exc_vector;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;

  logic [20:0] x_rst, x_fw, x_fr, x_dec, x_ex_mem, x_ex_r, x_ex_beq, x_ex_j;
  logic [20:0] x_mem_lw, x_mem_sw, x_wb_r, x_wb_lw, x_wb_addi, x_exc;

  multicycle_ctrl #(.DATA_W(32), .EXC_VECTOR(32'h180)) dut (
    .clock       (clock),
    .reset       (reset),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .ALUOp       (ALUOp),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IorD        (IorD),
    .RegWrite    (RegWrite),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .ALUSrcA     (ALUSrcA),
    .EPCWrite    (EPCWrite),
    .exc_vector  (exc_vector),
    .state_o     (state_o)
  );

  always #5 clock = ~clock;

  // Packing order: state, mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite,
  // PCWriteCond, RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, EPCWrite.
  function automatic logic [20:0] mk(input logic [2:0] st, input logic rd, wr, iord, irw,
                                     pcw, pcwc, rw, rdst, m2r, asa,
                                     input logic [1:0] asb, aop, pcs, input logic epc);
    return {st, rd | wr, rd, wr, iord, irw, pcw, pcwc, rw, rdst, m2r, asa, asb, aop, pcs, epc};
  endfunction

  function automatic logic [20:0] ctl();
    return {state_o, mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
            RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, EPCWrite};
  endfunction

  task automatic init_expect();
    //            st   rd wr io ir pw pc rw rd m2 sa  srcb   aop    pcs   epc
    x_rst     = mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    x_fw      = mk(3'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    x_fr      = mk(3'd1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    x_dec     = mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
    x_ex_mem  = mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
    x_ex_r    = mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
    x_ex_beq  = mk(3'd3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
    x_ex_j    = mk(3'd3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);
    x_mem_lw  = mk(3'd4, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    x_mem_sw  = mk(3'd4, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    x_wb_r    = mk(3'd5, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    x_wb_lw   = mk(3'd5, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
    x_wb_addi = mk(3'd5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    x_exc     = mk(3'd6, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 1);
  endtask

  // Drives one cycle's inputs just after the falling edge; outputs settle by #1.
  task automatic cyc(input logic rdy);
    @(negedge clock);
    mem_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    opcode = 6'h00;
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1);
      checks++;
      if (ctl() !== x_rst) begin
        errors++;
        $display("FAIL reset[%0d] got %h want %h", i, ctl(), x_rst);
      end
    end
    checks++;
    if (exc_vector !== 32'h180) begin
      errors++;
      $display("FAIL exc_vector got %h want %h", exc_vector, 32'h180);
    end
    @(negedge clock);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (ctl() !== x_fw) begin
      errors++;
      $display("FAIL reset_release got %h want %h", ctl(), x_fw);
    end
  endtask

  task automatic test_rtype();
    logic [20:0] exp [5];
    exp = '{x_fr, x_dec, x_ex_r, x_wb_r, x_fw};
    opcode = 6'h00;
    for (int i = 0; i < 5; i++) begin
      cyc(i < 4);
      checks++;
      if (ctl() !== exp[i]) begin
        errors++;
        $display("FAIL rtype[%0d] got %h want %h", i, ctl(), exp[i]);
      end
    end
  endtask

  task automatic test_lw_waits();
    logic [20:0] exp [11];
    logic        rdy [11];
    exp = '{x_fw, x_fw, x_fr, x_dec, x_ex_mem, x_mem_lw, x_mem_lw, x_mem_lw, x_mem_lw,
            x_wb_lw, x_fw};
    rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    opcode = 6'h23;
    for (int i = 0; i < 11; i++) begin
      cyc(rdy[i]);
      checks++;
      if (ctl() !== exp[i]) begin
        errors++;
        $display("FAIL lw_wait[%0d] got %h want %h", i, ctl(), exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] exp [11];
    logic [5:0]  ops [11];
    exp = '{x_fr, x_dec, x_ex_mem, x_mem_sw,
            x_fr, x_dec, x_ex_beq,
            x_fr, x_dec, x_ex_j, x_fw};
    ops = '{6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h04, 6'h04, 6'h04, 6'h02, 6'h02, 6'h02, 6'h02};
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      opcode = ops[i];
      mem_ready = (i < 10);
      #1;
      checks++;
      if (ctl() !== exp[i]) begin
        errors++;
        $display("FAIL sw_beq_j[%0d] got %h want %h", i, ctl(), exp[i]);
      end
    end
  endtask

  task automatic test_addi();
    logic [20:0] exp [5];
    exp = '{x_fr, x_dec, x_ex_mem, x_wb_addi, x_fw};
    opcode = 6'h08;
    for (int i = 0; i < 5; i++) begin
      cyc(i < 4);
      checks++;
      if (ctl() !== exp[i]) begin
        errors++;
        $display("FAIL addi[%0d] got %h want %h", i, ctl(), exp[i]);
      end
    end
  endtask

  task automatic test_illegal();
`ifdef MULTICYCLE_CTRL_EXC_EN
    logic [20:0] exp [4];
    exp = '{x_fr, x_dec, x_exc, x_fw};
`else
    logic [20:0] exp [4];
    exp = '{x_fr, x_dec, x_fw, x_fw};
`endif
    opcode = 6'h3F;
    for (int i = 0; i < 4; i++) begin
      cyc(i < 2);
      checks++;
      if (ctl() !== exp[i]) begin
        errors++;
        $display("FAIL illegal[%0d] got %h want %h", i, ctl(), exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [20:0] exp [4];
    exp = '{x_fr, x_dec, x_ex_mem, x_mem_lw};
    opcode = 6'h23;
    for (int i = 0; i < 4; i++) begin
      cyc(i < 3);
      checks++;
      if (ctl() !== exp[i]) begin
        errors++;
        $display("FAIL rst_mem_pre[%0d] got %h want %h", i, ctl(), exp[i]);
      end
    end
    // Assert reset mid-wait; the request must vanish without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (ctl() !== x_rst) begin
      errors++;
      $display("FAIL rst_mem_async got %h want %h", ctl(), x_rst);
    end
    cyc(1'b1);
    checks++;
    if (ctl() !== x_rst) begin
      errors++;
      $display("FAIL rst_mem_hold got %h want %h", ctl(), x_rst);
    end
    @(negedge clock);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (ctl() !== x_fw) begin
      errors++;
      $display("FAIL rst_mem_release got %h want %h", ctl(), x_fw);
    end
  endtask

  initial begin
    init_expect();
    test_reset();
    test_rtype();
    test_lw_waits();
    test_back_to_back();
    test_addi();
    test_illegal();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
